// File: rtl/fetch_if.sv
// Handshake bundle between the fetch stage and its environment: control in,
// IF/ID register and decoded fields out.
interface fetch_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            PCSrc;
  logic [XLEN-1:0] ImmExt;
  logic            load_en;
  logic [XLEN-1:0] load_addr;
  logic [31:0]     load_data;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [6:0]      op;
  logic [2:0]      funct3;
  logic            funct7;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            valid;

  modport master (
    output stall, PCSrc, ImmExt, load_en, load_addr, load_data,
    input  instr, pc, pc_plus4, op, funct3, funct7, rd, rs1, rs2, valid
  );

  modport slave (
    input  stall, PCSrc, ImmExt, load_en, load_addr, load_data,
    output instr, pc, pc_plus4, op, funct3, funct7, rd, rs1, rs2, valid
  );
endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage: PC register, word-addressed instruction memory with a
// loader write port, and the IF/ID register feeding the decoder.
module fetch #(
  parameter int              XLEN       = 32,
  parameter int              IMEM_DEPTH = 256,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
  input logic     clk,
  input logic     rst,
  fetch_if.slave  bus
);
  localparam int          AW  = $clog2(IMEM_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] FOUR = {{(XLEN-3){1'b0}}, 3'd4};

  logic [31:0]     imem_q [IMEM_DEPTH];
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] target_s;
  logic [31:0]     fetch_word_s;
  logic            load_addr_unused;

  // Word index within the memory; upper address bits alias, byte offset dropped.
  function automatic logic [AW-1:0] imem_idx(input logic [XLEN-1:0] addr);
    return addr[AW+1:2];
  endfunction

  assign load_addr_unused = ^{bus.load_addr[XLEN-1:AW+2], bus.load_addr[1:0]};
  assign target_s         = pc_q + bus.ImmExt;
  assign fetch_word_s     = imem_q[imem_idx(pc_f_q)];

  // Loader write port; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.load_en) begin
      imem_q[imem_idx(bus.load_addr)] <= bus.load_data;
    end
  end

  // Next-state selection: load > stall > taken redirect > sequential fetch.
  always_comb begin
    pc_f_d  = pc_f_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (bus.load_en) begin
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (bus.stall) begin
      pc_f_d  = pc_f_q;
    end else if (bus.PCSrc && valid_q) begin
      // A bubble in ID can never redirect, so a stale PCSrc is harmless.
      pc_f_d  = {target_s[XLEN-1:1], 1'b0};
      instr_d = NOP;
      valid_d = 1'b0;
    end else begin
      instr_d = fetch_word_s;
      pc_d    = pc_f_q;
      valid_d = 1'b1;
      pc_f_d  = pc_f_q + FOUR;
    end
  end

  // PC and IF/ID state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f_q  <= RESET_PC;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else begin
      pc_f_q  <= pc_f_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign bus.instr    = instr_q;
  assign bus.pc       = pc_q;
  assign bus.valid    = valid_q;
  assign bus.pc_plus4 = pc_q + FOUR;
  assign bus.op       = instr_q[6:0];
  assign bus.funct3   = instr_q[14:12];
  assign bus.funct7   = instr_q[30];
  assign bus.rd       = instr_q[11:7];
  assign bus.rs1      = instr_q[19:15];
  assign bus.rs2      = instr_q[24:20];
endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for the fetch stage, built with a 16-word instruction memory
// so address wrap-around is reachable.
module tb_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } exp_t;

  logic clk;
  logic rst;
  fetch_if #(.XLEN(32)) bus ();

  fetch #(.XLEN(32), .IMEM_DEPTH(16), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  logic [31:0] words[16];
  int          n_checks = 0;
  int          n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.load_en   = 1'b1;
      bus.load_addr = 32'(i * 4);
      bus.load_data = words[i];
      tick();
    end
    bus.load_en = 1'b0;
    n_checks++;
    if (bus.pc !== 32'h0 || bus.instr !== NOP || bus.valid !== 1'b0 || bus.pc_plus4 !== 32'h4) begin
      n_fail++;
      $display("FAIL reset_regs: pc=%h instr=%h valid=%b pc_plus4=%h, expected 0/00000013/0/4",
               bus.pc, bus.instr, bus.valid, bus.pc_plus4);
    end
    n_checks++;
    if (bus.op !== 7'b0010011 || bus.funct3 !== 3'd0 || bus.funct7 !== 1'b0 ||
        bus.rd !== 5'd0 || bus.rs1 !== 5'd0 || bus.rs2 !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_fields: op=%b f3=%0d f7=%b rd=%0d rs1=%0d rs2=%0d, expected NOP fields",
               bus.op, bus.funct3, bus.funct7, bus.rd, bus.rs1, bus.rs2);
    end
  endtask

  task automatic test_sequential();
    logic [6:0] ops[4];
    exp_t e;
    ops[0] = 7'b0010011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back('{32'(k * 4), words[k], 1'b1});
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (bus.pc !== e.pc || bus.instr !== e.instr || bus.valid !== e.valid || bus.op !== ops[k]) begin
        n_fail++;
        $display("FAIL seq_%0d: pc=%h instr=%h valid=%b op=%b, expected pc=%h instr=%h valid=%b op=%b",
                 k, bus.pc, bus.instr, bus.valid, bus.op, e.pc, e.instr, e.valid, ops[k]);
      end
      if (k == 1) begin
        n_checks++;
        if (bus.rd !== 5'd1 || bus.funct3 !== 3'd0 || bus.pc_plus4 !== 32'h8) begin
          n_fail++;
          $display("FAIL seq_fields: rd=%0d funct3=%0d pc_plus4=%h, expected 1/0/8",
                   bus.rd, bus.funct3, bus.pc_plus4);
        end
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) exp_q.push_back('{32'(k * 4), words[k], 1'b1});
    exp_q.push_back('{32'h8, NOP, 1'b0});
    exp_q.push_back('{32'h0, words[0], 1'b1});
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin
        bus.PCSrc  = 1'b1;
        bus.ImmExt = 32'hFFFF_FFF8;
      end else begin
        bus.PCSrc  = 1'b0;
      end
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (bus.pc !== e.pc || bus.instr !== e.instr || bus.valid !== e.valid) begin
        n_fail++;
        $display("FAIL branch_%0d: pc=%h instr=%h valid=%b, expected pc=%h instr=%h valid=%b",
                 k, bus.pc, bus.instr, bus.valid, e.pc, e.instr, e.valid);
      end
    end
    bus.PCSrc = 1'b0;
  endtask

  task automatic test_stall();
    exp_t e;
    // Per step: stall, PCSrc, then the expected IF/ID contents after the edge.
    logic st[9];
    logic br[9];
    st = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    br = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_q.push_back('{32'h4, words[1], 1'b1});
    for (int k = 0; k < 3; k++) exp_q.push_back('{32'h4, words[1], 1'b1});
    exp_q.push_back('{32'h8, words[2], 1'b1});
    exp_q.push_back('{32'h8, words[2], 1'b1});
    exp_q.push_back('{32'h8, words[2], 1'b1});
    exp_q.push_back('{32'h8, NOP, 1'b0});
    exp_q.push_back('{32'h4, words[1], 1'b1});
    bus.ImmExt = 32'hFFFF_FFFC;
    for (int k = 0; k < 9; k++) begin
      bus.stall = st[k];
      bus.PCSrc = br[k];
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (bus.pc !== e.pc || bus.instr !== e.instr || bus.valid !== e.valid) begin
        n_fail++;
        $display("FAIL stall_%0d: pc=%h instr=%h valid=%b, expected pc=%h instr=%h valid=%b",
                 k, bus.pc, bus.instr, bus.valid, e.pc, e.instr, e.valid);
      end
    end
    bus.stall = 1'b0;
    bus.PCSrc = 1'b0;
    exp_q.push_back('{32'h8, words[2], 1'b1});
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (bus.pc !== e.pc || bus.instr !== e.instr || bus.valid !== e.valid) begin
      n_fail++;
      $display("FAIL stall_after: pc=%h instr=%h valid=%b, expected pc=%h instr=%h valid=%b",
               bus.pc, bus.instr, bus.valid, e.pc, e.instr, e.valid);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int k = 0; k < 17; k++) begin
      exp_q.push_back('{32'(k * 4), words[k % 16], 1'b1});
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (bus.pc !== e.pc || bus.instr !== e.instr || bus.valid !== e.valid) begin
        n_fail++;
        $display("FAIL wrap_%0d: pc=%h instr=%h valid=%b, expected pc=%h instr=%h valid=%b",
                 k, bus.pc, bus.instr, bus.valid, e.pc, e.instr, e.valid);
      end
    end
    n_checks++;
    if (bus.pc_plus4 !== 32'd68) begin
      n_fail++;
      $display("FAIL wrap_pc_plus4: got %h, expected %h", bus.pc_plus4, 32'd68);
    end
  endtask

  task automatic test_loader();
    exp_t e;
    logic ld[5];
    logic br[5];
    ld = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    br = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    words[2] = 32'h0010_0113;
    exp_q.push_back('{32'd64, NOP, 1'b0});
    exp_q.push_back('{32'd64, NOP, 1'b0});
    exp_q.push_back('{32'd68, words[1], 1'b1});
    exp_q.push_back('{32'd68, NOP, 1'b0});
    exp_q.push_back('{32'd8, 32'h0010_0113, 1'b1});
    bus.load_addr = 32'd8;
    bus.load_data = 32'h0010_0113;
    // 68 - 59 = 9; bit 0 is cleared, giving target 8.
    bus.ImmExt    = 32'hFFFF_FFC5;
    for (int k = 0; k < 5; k++) begin
      bus.load_en = ld[k];
      bus.PCSrc   = br[k];
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (bus.pc !== e.pc || bus.instr !== e.instr || bus.valid !== e.valid) begin
        n_fail++;
        $display("FAIL loader_%0d: pc=%h instr=%h valid=%b, expected pc=%h instr=%h valid=%b",
                 k, bus.pc, bus.instr, bus.valid, e.pc, e.instr, e.valid);
      end
    end
    bus.load_en = 1'b0;
    bus.PCSrc   = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back('{32'(k * 4), words[k], 1'b1});
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (bus.pc !== e.pc || bus.instr !== e.instr || bus.valid !== e.valid) begin
        n_fail++;
        $display("FAIL arst_run_%0d: pc=%h instr=%h valid=%b, expected pc=%h instr=%h valid=%b",
                 k, bus.pc, bus.instr, bus.valid, e.pc, e.instr, e.valid);
      end
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.pc !== 32'h0 || bus.instr !== NOP || bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_immediate: pc=%h instr=%h valid=%b, expected pc=0 instr=00000013 valid=0",
               bus.pc, bus.instr, bus.valid);
    end
    rst = 1'b0;
    exp_q.push_back('{32'h0, words[0], 1'b1});
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (bus.pc !== e.pc || bus.instr !== e.instr || bus.valid !== e.valid) begin
      n_fail++;
      $display("FAIL arst_resume: pc=%h instr=%h valid=%b, expected pc=%h instr=%h valid=%b",
               bus.pc, bus.instr, bus.valid, e.pc, e.instr, e.valid);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.stall     = 1'b0;
    bus.PCSrc     = 1'b0;
    bus.ImmExt    = 32'h0;
    bus.load_en   = 1'b0;
    bus.load_addr = 32'h0;
    bus.load_data = 32'h0;
    words[0] = 32'h0000_0013;
    words[1] = 32'h0050_0093;
    words[2] = 32'h0000_a103;
    words[3] = 32'h0020_2223;
    for (int i = 4; i < 16; i++) words[i] = 32'h0000_0013 | (32'(i) << 7);
    #2;
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_wrap();
    test_loader();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
